// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes fetch and data-port accesses onto one single-port memory with ready handshake.
// Define MEM_ARB_RR_EN for round-robin conflict resolution (default: data port has fixed priority).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic we_q, we_d, if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic if_elig, dm_elig, pick_dm, grant;
  assign if_elig = if_req_i & ~if_ack_q;
  assign dm_elig = dm_req_i & ~dm_ack_q;
  assign grant   = if_elig | dm_elig;
`ifdef MEM_ARB_RR_EN
  // last_dm_q = 1 when the data port won the most recent grant
  logic last_dm_q, last_dm_d;
  assign pick_dm   = dm_elig & (~if_elig | ~last_dm_q);
  assign last_dm_d = (state_q == IDLE && grant) ? pick_dm : last_dm_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) last_dm_q <= 1'b0;
    else          last_dm_q <= last_dm_d;
`else
  assign pick_dm = dm_elig;
`endif
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    case (state_q)
      IDLE: if (grant) begin
        state_d = pick_dm ? ACC_DM : ACC_IF;
        addr_d  = pick_dm ? dm_addr_i : if_addr_i;
        we_d    = pick_dm & dm_we_i;
        wdata_d = pick_dm ? dm_wdata_i : wdata_q;
      end
      ACC_IF: if (mem_ready_i) begin
        state_d    = IDLE;
        if_ack_d   = 1'b1;
        if_rdata_d = mem_rdata_i;
      end
      ACC_DM: if (mem_ready_i) begin
        state_d    = IDLE;
        dm_ack_d   = 1'b1;
        dm_rdata_d = we_q ? dm_rdata_q : mem_rdata_i;
      end
      default: state_d = IDLE;
    endcase
  end
  assign if_stall_o = if_req_i & ~if_ack_q;
  assign dm_stall_o = dm_req_i & ~dm_ack_q;
  assign cnt_d = ((if_stall_o | dm_stall_o) && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      cnt_q      <= cnt_d;
    end
  assign mem_en_o    = state_q != IDLE;
  assign mem_we_o    = we_q & mem_en_o;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, wait states, reset abort and counter saturation.
module tb_mem_port_arbiter;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic if_req_i = 0, dm_req_i = 0, dm_we_i = 0, mem_ready_i = 0;
  logic [31:0] if_addr_i = 0, dm_addr_i = 0, dm_wdata_i = 0, mem_rdata_i = 0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, stall_cnt_o;
  logic if_ack_o, if_stall_o, dm_ack_o, dm_stall_o, mem_en_o, mem_we_o;
  logic [31:0] s_if_rdata, s_dm_rdata, s_addr, s_wdata;
  logic s_if_ack, s_if_stall, s_dm_ack, s_dm_stall, s_en, s_we;
  logic [3:0] s_cnt;
  int n_tests = 0, n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .dm_stall_o(dm_stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .stall_cnt_o(stall_cnt_o)
  );

  mem_port_arbiter #(.CNT_W(4)) u_sat (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(s_if_rdata),
    .if_ack_o(s_if_ack), .if_stall_o(s_if_stall),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(s_dm_rdata), .dm_ack_o(s_dm_ack), .dm_stall_o(s_dm_stall),
    .mem_en_o(s_en), .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .stall_cnt_o(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_n_i = 0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ready_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1;
  endtask

  initial begin
    do_reset;
    #2;
    chk("rst_en", mem_en_o, 0);          chk("rst_we", mem_we_o, 0);
    chk("rst_ifack", if_ack_o, 0);       chk("rst_dmack", dm_ack_o, 0);
    chk("rst_addr", mem_addr_o, 0);      chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_ifrd", if_rdata_o, 0);      chk("rst_dmrd", dm_rdata_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    // single fetch, zero wait
    if_req_i = 1; if_addr_i = 32'h10;
    #2 chk("f_stall0", if_stall_o, 1); chk("f_en0", mem_en_o, 0);
    tick;
    mem_ready_i = 1; mem_rdata_i = 32'hDEADBEEF;
    #2 chk("f_en1", mem_en_o, 1); chk("f_addr1", mem_addr_o, 32'h10); chk("f_we1", mem_we_o, 0);
    chk("f_stall1", if_stall_o, 1);
    tick;
    mem_ready_i = 0;
    #2 chk("f_ack2", if_ack_o, 1); chk("f_rdata2", if_rdata_o, 32'hDEADBEEF);
    chk("f_stall2", if_stall_o, 0); chk("f_en2", mem_en_o, 0); chk("f_cnt2", stall_cnt_o, 2);
    tick;
    if_req_i = 0;
    #2 chk("f_ack3", if_ack_o, 0); chk("f_en3", mem_en_o, 0); chk("f_cnt3", stall_cnt_o, 2);
    // data read, zero wait
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h8;
    tick;
    mem_ready_i = 1; mem_rdata_i = 32'h12345678;
    #2 chk("r_addr1", mem_addr_o, 32'h8); chk("r_en1", mem_en_o, 1);
    tick;
    mem_ready_i = 0;
    #2 chk("r_ack2", dm_ack_o, 1); chk("r_rdata2", dm_rdata_o, 32'h12345678);
    chk("r_ifrd2", if_rdata_o, 32'hDEADBEEF);
    tick;
    // data write, ready in IDLE ignored, then 3 ACC cycles
    dm_we_i = 1; dm_addr_i = 32'h4; dm_wdata_i = 32'd5; mem_ready_i = 1; mem_rdata_i = 32'hBAD;
    #2 chk("w_en0", mem_en_o, 0); chk("w_ack0", dm_ack_o, 0);
    tick;
    mem_ready_i = 0;
    for (int i = 1; i <= 3; i++) begin
      mem_ready_i = (i == 3);
      #2 chk("w_en", mem_en_o, 1); chk("w_we", mem_we_o, 1);
      chk("w_wdata", mem_wdata_o, 32'd5); chk("w_addr", mem_addr_o, 32'h4);
      chk("w_noack", dm_ack_o, 0);
      tick;
    end
    mem_ready_i = 0;
    #2 chk("w_ack4", dm_ack_o, 1); chk("w_rdata4", dm_rdata_o, 32'h12345678);
    chk("w_cnt4", stall_cnt_o, 8);
    tick;
    dm_req_i = 0; dm_we_i = 0;
    tick;
    // conflict: dm first, then if, then dm again while both held
    do_reset;
    if_req_i = 1; if_addr_i = 32'h20; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h30;
    #2 chk("c_ifst0", if_stall_o, 1); chk("c_dmst0", dm_stall_o, 1);
    tick;
    mem_ready_i = 1; mem_rdata_i = 32'hA;
    #2 chk("c_addr1", mem_addr_o, 32'h30);
    tick;
    mem_ready_i = 0;
    #2 chk("c_dmack2", dm_ack_o, 1); chk("c_ifack2", if_ack_o, 0); chk("c_dmrd2", dm_rdata_o, 32'hA);
    tick;
    mem_ready_i = 1; mem_rdata_i = 32'hB;
    #2 chk("c_en3", mem_en_o, 1); chk("c_addr3", mem_addr_o, 32'h20); chk("c_cnt3", stall_cnt_o, 3);
    tick;
    mem_ready_i = 0;
    #2 chk("c_ifack4", if_ack_o, 1); chk("c_ifrd4", if_rdata_o, 32'hB); chk("c_dmack4", dm_ack_o, 0);
    chk("c_cnt4", stall_cnt_o, 4);
    tick;
    if_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'hC;
    #2 chk("c_en5", mem_en_o, 1); chk("c_addr5", mem_addr_o, 32'h30);
    tick;
    mem_ready_i = 0;
    #2 chk("c_dmack6", dm_ack_o, 1); chk("c_dmrd6", dm_rdata_o, 32'hC);
    dm_req_i = 0;
    tick;
    // reset during ACC_DM
    do_reset;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h40;
    tick;
    #2 chk("m_en1", mem_en_o, 1);
    rst_n_i = 0; mem_ready_i = 1;
    #1 chk("m_en_rst", mem_en_o, 0); chk("m_cnt_rst", stall_cnt_o, 0); chk("m_ack_rst", dm_ack_o, 0);
    tick;
    #2 chk("m_ack_rst2", dm_ack_o, 0);
    tick;
    rst_n_i = 1; mem_ready_i = 0;
    #2 chk("m_en_rel", mem_en_o, 0); chk("m_ack_rel", dm_ack_o, 0);
    tick;
    #2 chk("m_en_regrant", mem_en_o, 1); chk("m_addr", mem_addr_o, 32'h40); chk("m_ack_regrant", dm_ack_o, 0);
    mem_ready_i = 1;
    tick;
    mem_ready_i = 0;
    #2 chk("m_ack_done", dm_ack_o, 1);
    dm_req_i = 0;
    tick;
    // counter saturation on the 4-bit instance
    do_reset;
    if_req_i = 1;
    repeat (20) tick;
    #2 chk("s_cnt_sat", s_cnt, 15); chk("s_cnt_main", stall_cnt_o, 20);
    if_req_i = 0;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port unified memory between the CPU's instruction-fetch port and its MEM-stage data port. It serializes accesses, handles a variable-latency memory via a ready handshake, and produces per-port stall signals that feed the pipeline's stall logic. A saturating stall-cycle counter gives the bench an independent stall count.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- CNT_W, 32, stall counter width in bits

- clk_i  in  1  clock, rising-edge
- rst_n_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch read request, held until ack
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_stall_o  out  1  fetch port waiting
- dm_req_i  in  1  data request, held until ack
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data
- dm_ack_o  out  1  one-cycle data completion pulse
- dm_stall_o  out  1  data port waiting
- mem_en_o  out  1  memory command valid
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ready_i
- mem_ready_i  in  1  memory completion, any cycle with mem_en_o=1
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- States: IDLE, ACC_IF, ACC_DM.
- IDLE: a port is eligible if its req_i=1 and its ack_o is not high this cycle. If exactly one is eligible, grant it; if both, apply the priority rule. On grant, register address, we and wdata (fetch: we=0); next state is ACC_IF or ACC_DM.
- ACC_x: mem_en_o=1, and mem_we_o/addr/wdata come from the registered command, stable until completion. When mem_ready_i=1:
  - next state is IDLE;
  - x_ack_o=1 in the following cycle only;
  - for a read, x_rdata_o captures mem_rdata_i.
- A write never changes dm_rdata_o. rdata outputs hold their last value until the next read completion on that port.
- mem_ready_i in IDLE is ignored.
- Default priority: dm wins a conflict (older instruction first).
- x_stall_o = x_req_i & ~x_ack_o, combinational.
- stall_cnt_o increments by 1 each cycle with (if_stall_o | dm_stall_o)=1 and saturates at all-ones.
- Requester drops req mid-access: the access still completes and the ack still pulses.
- Reset values (async): state IDLE; mem_en_o, mem_we_o, if_ack_o, dm_ack_o = 0; mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o, stall_cnt_o = 0.
- Reset mid-access aborts the access: mem_en_o falls immediately and no ack is issued. After reset release, still-asserted requests re-arbitrate from IDLE.

## Timing
- Minimum latency, req to ack: req in cycle 0, mem_en_o in cycle 1, mem_ready_i in cycle 1, ack in cycle 2. Stall is high in cycles 0–1.
- Each extra cycle without mem_ready_i adds 1 cycle of latency.
- Back-to-back: IDLE can grant the other port in the ack cycle, so its mem_en_o rises one cycle after the ack. The acked port is masked in its ack cycle.
- Throughput: one access per 2 cycles at best.
- ack and rdata are registered. Stall is combinational from req_i and ack.

## Configuration
- MEM_ARB_RR_EN defined: round-robin priority. A 1-bit last-grant flag (reset = fetch) is updated on every grant. On conflict, the port not granted last wins.
- MEM_ARB_RR_EN undefined: fixed priority, dm over if, and no last-grant flag exists.
- Single-requester behaviour is identical in both builds.

## Test plan
- Single fetch:
  - Stimulus: if_req_i=1, if_addr_i=0x10, mem_ready_i in the first ACC cycle, mem_rdata_i=0xDEADBEEF.
  - Response: if_ack_o in cycle 2, if_rdata_o=0xDEADBEEF, stall_cnt_o=2.
- Data write with memory wait:
  - Stimulus: dm_we_i=1, dm_addr_i=0x04, dm_wdata_i=5, mem_ready_i after 3 ACC cycles.
  - Response: mem_we_o=1 and mem_wdata_o=5 stable for 3 cycles, dm_ack_o in cycle 4, dm_rdata_o unchanged.
- Conflict:
  - Stimulus: both ports request in the same cycle, zero-wait memory.
  - Response, fixed build: dm is served first (ack cycle 2), if second (ack cycle 4).
  - Response, MEM_ARB_RR_EN build after reset: dm first. With both requests held continuously, grants alternate.
- Reset mid-access:
  - Stimulus: assert rst_n_i=0 during ACC_DM.
  - Response: mem_en_o=0 asynchronously, no dm_ack_o, stall_cnt_o=0.
  - After release with dm_req_i held: re-grant, with mem_en_o one cycle after release.
- Counter saturation (CNT_W=4):
  - Stimulus: hold a request with mem_ready_i=0 for 20 cycles.
  - Response: stall_cnt_o stops at 15.
